// File: rtl/gray_updown_counter_pkg.sv
// Shared Gray-code helpers for the up/down counter and its load path.
// Functions operate on a fixed 32-bit container; callers zero-extend and
// take the low WIDTH bits, which is exact because both transforms only
// propagate information from higher to lower bit positions.
package gray_updown_counter_pkg;

    localparam int FUNC_W = 32;

    function automatic logic [FUNC_W-1:0] bin2gray_f(input logic [FUNC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FUNC_W-1:0] gray2bin_f(input logic [FUNC_W-1:0] g);
        logic [FUNC_W-1:0] b;
        logic              acc;
        b   = '0;
        acc = 1'b0;
        for (int i = FUNC_W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_updown_counter_gray2bin.sv
// Combinational Gray-to-binary converter for the parallel-load path.
// Running XOR from the MSB down: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
module gray_updown_counter_gray2bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Prefix XOR carried in a scalar accumulator so no bit of bin is read back.
    always_comb begin
        logic acc;
        bin = '0;
        acc = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter held in binary with a registered Gray image.
// The Gray register is fed from the next-state binary, so bin_out and
// gray_out change on the same edge with no skew between them.
// WRAP=1 wraps modulo 2^WIDTH and pulses wrap_p; WRAP=0 pins at the ends
// and raises sat until the count moves again or a load occurs.
module gray_updown_counter
    import gray_updown_counter_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter bit               WRAP    = 1'b1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap_p,
    output logic             sat
);

    localparam logic [WIDTH-1:0]  CNT_MAX    = '1;
    localparam logic [FUNC_W-1:0] RST_GRAY_W = bin2gray_f(FUNC_W'(RST_VAL));
    localparam logic [WIDTH-1:0]  RST_GRAY   = RST_GRAY_W[WIDTH-1:0];

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;
    logic             sat_next;

    gray_updown_counter_gray2bin #(
        .WIDTH(WIDTH)
    ) u_gray2bin (
        .gray(load_gray),
        .bin (load_bin)
    );

    // Next-state mux: load beats enable; end-of-range handling depends on WRAP.
    always_comb begin
        bin_next  = bin_out;
        wrap_next = 1'b0;
        sat_next  = sat;
        if (load) begin
            bin_next = load_bin;
            sat_next = 1'b0;
        end else if (en) begin
            if (up) begin
                if (bin_out == CNT_MAX) begin
                    if (WRAP) begin
                        bin_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        sat_next = 1'b1;
                    end
                end else begin
                    bin_next = bin_out + 1'b1;
                    sat_next = 1'b0;
                end
            end else begin
                if (bin_out == '0) begin
                    if (WRAP) begin
                        bin_next  = CNT_MAX;
                        wrap_next = 1'b1;
                    end else begin
                        sat_next = 1'b1;
                    end
                end else begin
                    bin_next = bin_out - 1'b1;
                    sat_next = 1'b0;
                end
            end
        end
    end

    // Gray image of the next state; on load this equals load_gray.
    always_comb begin
        gray_next = bin_next ^ (bin_next >> 1);
    end

    // State, Gray output and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_out  <= RST_VAL;
            gray_out <= RST_GRAY;
            wrap_p   <= 1'b0;
            sat      <= 1'b0;
        end else begin
            bin_out  <= bin_next;
            gray_out <= gray_next;
            wrap_p   <= wrap_next;
            sat      <= sat_next;
        end
    end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: three instances sharing one stimulus stream
// (wrap/RST_VAL=0, saturate/RST_VAL=0, wrap/RST_VAL=0x0A), each tracked by an
// arithmetic reference model.
module tb_gray_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_gray;

    logic [7:0] bin_o  [3];
    logic [7:0] gray_o [3];
    logic       wrap_o [3];
    logic       sat_o  [3];

    int  checks = 0;
    int  errors = 0;

    int  m_bin  [3];
    bit  m_wrap [3];
    bit  m_sat  [3];
    int  rstv   [3] = '{0, 0, 10};
    bit  mode   [3] = '{1'b1, 1'b0, 1'b1};

    gray_updown_counter #(.WIDTH(8), .WRAP(1'b1), .RST_VAL(8'h00)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .bin_out(bin_o[0]), .gray_out(gray_o[0]), .wrap_p(wrap_o[0]), .sat(sat_o[0]));

    gray_updown_counter #(.WIDTH(8), .WRAP(1'b0), .RST_VAL(8'h00)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .bin_out(bin_o[1]), .gray_out(gray_o[1]), .wrap_p(wrap_o[1]), .sat(sat_o[1]));

    gray_updown_counter #(.WIDTH(8), .WRAP(1'b1), .RST_VAL(8'h0A)) dut_rst (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .bin_out(bin_o[2]), .gray_out(gray_o[2]), .wrap_p(wrap_o[2]), .sat(sat_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray decode by definition: binary bit i is the parity of Gray bits i and above.
    function automatic int gray_decode(input logic [7:0] g);
        int v;
        logic [7:0] sh;
        v = 0;
        for (int i = 0; i < 8; i++) begin
            sh = g >> i;
            if (($countones(sh) % 2) == 1) v = v + (1 << i);
        end
        return v;
    endfunction

    function automatic logic [7:0] exp_gray(input int v);
        logic [7:0] b;
        b = 8'(v);
        return b ^ (b >> 1);
    endfunction

    // Reference behaviour on one rising edge, from the current inputs.
    function automatic void model_edge();
        int n;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_bin[d] = rstv[d]; m_wrap[d] = 1'b0; m_sat[d] = 1'b0;
            end else if (load) begin
                m_bin[d] = gray_decode(load_gray); m_wrap[d] = 1'b0; m_sat[d] = 1'b0;
            end else if (en) begin
                n = m_bin[d] + (up ? 1 : -1);
                m_wrap[d] = 1'b0;
                if (n < 0 || n > 255) begin
                    if (mode[d]) begin
                        m_bin[d] = (n + 256) % 256; m_wrap[d] = 1'b1;
                    end else begin
                        m_sat[d] = 1'b1;
                    end
                end else begin
                    m_bin[d] = n; m_sat[d] = 1'b0;
                end
            end else begin
                m_wrap[d] = 1'b0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic r, input logic e, input logic u, input logic l, input logic [7:0] g);
        rst_n = r; en = e; up = u; load = l; load_gray = g;
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom));
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bin_o[d] !== 8'(m_bin[d])) begin errors++; $display("FAIL reset_bin dut%0d got %h exp %h", d, bin_o[d], 8'(m_bin[d])); end
            checks++;
            if (gray_o[d] !== exp_gray(m_bin[d])) begin errors++; $display("FAIL reset_gray dut%0d got %h exp %h", d, gray_o[d], exp_gray(m_bin[d])); end
            checks++;
            if (wrap_o[d] !== 1'b0 || sat_o[d] !== 1'b0) begin errors++; $display("FAIL reset_flags dut%0d got wrap=%b sat=%b exp 0 0", d, wrap_o[d], sat_o[d]); end
        end
        checks++;
        if (bin_o[2] !== 8'h0A || gray_o[2] !== 8'h0F) begin errors++; $display("FAIL reset_rstval got bin=%h gray=%h exp 0a 0f", bin_o[2], gray_o[2]); end
    endtask

    task automatic test_up_sweep();
        logic [7:0] prev;
        int wraps;
        wraps = 0;
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 256; c++) begin
            prev = exp_gray(m_bin[0]);
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (bin_o[d] !== 8'(m_bin[d]) || gray_o[d] !== exp_gray(m_bin[d]) ||
                    wrap_o[d] !== m_wrap[d] || sat_o[d] !== m_sat[d]) begin
                    errors++;
                    $display("FAIL up_sweep dut%0d cyc %0d got bin=%h gray=%h w=%b s=%b exp bin=%h gray=%h w=%b s=%b",
                             d, c, bin_o[d], gray_o[d], wrap_o[d], sat_o[d], 8'(m_bin[d]), exp_gray(m_bin[d]), m_wrap[d], m_sat[d]);
                end
            end
            checks++;
            if ($countones(gray_o[0] ^ prev) != 1) begin errors++; $display("FAIL up_hamming cyc %0d got %h prev %h exp 1 bit change", c, gray_o[0], prev); end
            if (wrap_o[0] === 1'b1) wraps++;
            if (c == 255) begin
                checks++;
                if (bin_o[0] !== 8'h00 || gray_o[0] !== 8'h00 || prev !== 8'h80 || wrap_o[0] !== 1'b1) begin
                    errors++; $display("FAIL up_wrap got bin=%h gray=%h w=%b exp 00 00 1", bin_o[0], gray_o[0], wrap_o[0]);
                end
            end
        end
        checks++;
        if (wraps != 1) begin errors++; $display("FAIL up_wrap_count got %0d exp 1", wraps); end
    endtask

    task automatic test_saturate();
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bin_o[1] !== 8'hFF || gray_o[1] !== 8'h80 || sat_o[1] !== 1'b1 || wrap_o[1] !== 1'b0) begin
                errors++; $display("FAIL sat_hold got bin=%h gray=%h s=%b w=%b exp ff 80 1 0", bin_o[1], gray_o[1], sat_o[1], wrap_o[1]);
            end
        end
        up = 1'b0;
        tick();
        checks++;
        if (bin_o[1] !== 8'hFE || sat_o[1] !== 1'b0) begin errors++; $display("FAIL sat_release got bin=%h s=%b exp fe 0", bin_o[1], sat_o[1]); end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bin_o[d] !== 8'(m_bin[d]) || sat_o[d] !== m_sat[d]) begin errors++; $display("FAIL sat_model dut%0d got %h exp %h", d, bin_o[d], 8'(m_bin[d])); end
        end
    endtask

    task automatic test_down_wrap();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        checks++;
        if (bin_o[0] !== 8'hFF || gray_o[0] !== 8'h80 || wrap_o[0] !== 1'b1) begin errors++; $display("FAIL down_wrap got bin=%h gray=%h w=%b exp ff 80 1", bin_o[0], gray_o[0], wrap_o[0]); end
        checks++;
        if (bin_o[1] !== 8'h00 || sat_o[1] !== 1'b1) begin errors++; $display("FAIL down_sat got bin=%h s=%b exp 00 1", bin_o[1], sat_o[1]); end
        tick();
        checks++;
        if (bin_o[0] !== 8'hFE || gray_o[0] !== 8'h81 || wrap_o[0] !== 1'b0) begin errors++; $display("FAIL down_next got bin=%h gray=%h w=%b exp fe 81 0", bin_o[0], gray_o[0], wrap_o[0]); end
    endtask

    task automatic test_load();
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 8'hC0);
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bin_o[d] !== 8'h80 || gray_o[d] !== 8'hC0 || sat_o[d] !== 1'b0 || wrap_o[d] !== 1'b0) begin
                errors++; $display("FAIL load dut%0d got bin=%h gray=%h exp 80 c0", d, bin_o[d], gray_o[d]);
            end
        end
        load = 1'b0;
        tick();
        checks++;
        if (bin_o[0] !== 8'h81 || gray_o[0] !== 8'hC1) begin errors++; $display("FAIL load_step got bin=%h gray=%h exp 81 c1", bin_o[0], gray_o[0]); end
        for (int c = 0; c < 20; c++) begin
            set_in(1'b1, 1'($urandom), 1'($urandom), 1'b1, 8'($urandom));
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (bin_o[d] !== 8'(m_bin[d]) || gray_o[d] !== load_gray) begin
                    errors++; $display("FAIL load_rand dut%0d got bin=%h gray=%h exp bin=%h gray=%h", d, bin_o[d], gray_o[d], 8'(m_bin[d]), load_gray);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 55; c++) tick();
        checks++;
        if (bin_o[0] !== 8'h37) begin errors++; $display("FAIL mid_count got %h exp 37", bin_o[0]); end
        rst_n = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bin_o[d] !== 8'(rstv[d]) || gray_o[d] !== exp_gray(rstv[d])) begin errors++; $display("FAIL mid_reset dut%0d got %h exp %h", d, bin_o[d], 8'(rstv[d])); end
        end
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bin_o[d] !== 8'(rstv[d] + 1)) begin errors++; $display("FAIL mid_resume dut%0d got %h exp %h", d, bin_o[d], 8'(rstv[d] + 1)); end
        end
    endtask

    task automatic test_random();
        logic [7:0] prev [3];
        int         prev_bin [3];
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 3; d++) begin prev[d] = exp_gray(m_bin[d]); prev_bin[d] = m_bin[d]; end
            set_in(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                   ($urandom_range(0, 29) == 0), 8'($urandom));
            if (c % 400 < 40) up = 1'b0;
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (bin_o[d] !== 8'(m_bin[d]) || gray_o[d] !== exp_gray(m_bin[d]) ||
                    wrap_o[d] !== m_wrap[d] || sat_o[d] !== m_sat[d]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got bin=%h gray=%h w=%b s=%b exp bin=%h gray=%h w=%b s=%b",
                             d, c, bin_o[d], gray_o[d], wrap_o[d], sat_o[d], 8'(m_bin[d]), exp_gray(m_bin[d]), m_wrap[d], m_sat[d]);
                end
                if (rst_n && !load) begin
                    checks++;
                    if ($countones(gray_o[d] ^ prev[d]) != ((m_bin[d] != prev_bin[d]) ? 1 : 0)) begin
                        errors++; $display("FAIL random_hamming dut%0d cyc %0d got %h prev %h", d, c, gray_o[d], prev[d]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin m_bin[d] = 0; m_wrap[d] = 1'b0; m_sat[d] = 1'b0; end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_up_sweep();
        test_saturate();
        test_down_wrap();
        test_load();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
